// File: rtl/mem_pkg.sv
// Shared encodings and FSM state type for the MEM-stage data-cache scheduler.
package mem_pkg;

    localparam logic [2:0] MT_NONE = 3'b000;
    localparam logic [2:0] MT_LDB  = 3'b001;
    localparam logic [2:0] MT_LDH  = 3'b010;
    localparam logic [2:0] MT_LDW  = 3'b011;
    localparam logic [2:0] MT_RSVD = 3'b100;
    localparam logic [2:0] MT_STB  = 3'b101;
    localparam logic [2:0] MT_STH  = 3'b110;
    localparam logic [2:0] MT_STW  = 3'b111;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_B    = 2'd1,
        SZ_H    = 2'd2,
        SZ_W    = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_REQ,
        S_A_WAIT,
        S_B_REQ,
        S_B_WAIT,
        S_DONE
    } state_e;

    function automatic logic is_store(input logic [2:0] t);
        return t[2] & (t[1:0] != 2'b00);
    endfunction

    // Reserved 3'b100 decodes to SZ_NONE through the low bits.
    function automatic size_e mem_size(input logic [2:0] t);
        return size_e'(t[1:0]);
    endfunction

endpackage

// File: rtl/mem_req_fmt.sv
// Per-lane request formatter: strobes, replicated store data, misalign flag.
module mem_req_fmt
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [2:0]        mem_type,
    input  logic [1:0]        addr_lo,
    input  logic [ADDR_W-1:0] data,
    output logic              op,
    output logic              we,
    output logic [3:0]        wstrb,
    output logic [ADDR_W-1:0] wdata,
    output logic              ale
);

    size_e             sz;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] rep;

    always_comb begin
        sz   = mem_size(mem_type);
        ale  = 1'b0;
        strb = 4'b0000;
        rep  = '0;
        unique case (sz)
            SZ_B: begin
                strb = 4'b0001 << addr_lo;
                rep  = {(ADDR_W/8){data[7:0]}};
            end
            SZ_H: begin
                ale  = addr_lo[0];
                strb = 4'b0011 << {addr_lo[1], 1'b0};
                rep  = {(ADDR_W/16){data[15:0]}};
            end
            SZ_W: begin
                ale  = |addr_lo;
                strb = 4'b1111;
                rep  = data;
            end
            default: ;
        endcase
        op    = (sz != SZ_NONE) && !ale;
        we    = op && is_store(mem_type);
        wstrb = we ? strb : 4'b0000;
        wdata = we ? rep : '0;
    end

endmodule

// File: rtl/mem_dcache_sched.sv
// Dual-issue MEM scheduler: serialises lane A then lane B onto one D$ port,
// stalling EX->MEM until both accesses of the bundle have responded.
module mem_dcache_sched
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        MEM_mem_type_a,
    input  logic [2:0]        MEM_mem_type_b,
    input  logic [ADDR_W-1:0] MEM_alu_result_a,
    input  logic [ADDR_W-1:0] MEM_alu_result_b,
    input  logic [ADDR_W-1:0] MEM_store_data_a,
    input  logic [ADDR_W-1:0] MEM_store_data_b,
    input  logic              MEM_kill_b,
    output logic              stall_dcache,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_req_we,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic [ADDR_W-1:0] dc_req_wdata,
    output logic [3:0]        dc_req_wstrb,
    input  logic              dc_resp_valid,
    input  logic [ADDR_W-1:0] dc_resp_rdata,
    output logic [ADDR_W-1:0] MEM_ld_data_a,
    output logic [ADDR_W-1:0] MEM_ld_data_b,
    output logic              MEM_ale_a,
    output logic              MEM_ale_b
);

    logic              op_a, we_a, op_b, we_b;
    logic [3:0]        strb_a, strb_b;
    logic [ADDR_W-1:0] wd_a, wd_b;
    logic [2:0]        type_b;

    assign type_b = MEM_kill_b ? MT_NONE : MEM_mem_type_b;

    mem_req_fmt #(.ADDR_W(ADDR_W)) u_fmt_a (
        .mem_type (MEM_mem_type_a),
        .addr_lo  (MEM_alu_result_a[1:0]),
        .data     (MEM_store_data_a),
        .op       (op_a),
        .we       (we_a),
        .wstrb    (strb_a),
        .wdata    (wd_a),
        .ale      (MEM_ale_a)
    );

    mem_req_fmt #(.ADDR_W(ADDR_W)) u_fmt_b (
        .mem_type (type_b),
        .addr_lo  (MEM_alu_result_b[1:0]),
        .data     (MEM_store_data_b),
        .op       (op_b),
        .we       (we_b),
        .wstrb    (strb_b),
        .wdata    (wd_b),
        .ale      (MEM_ale_b)
    );

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] ld_a_q, ld_a_d;
    logic [ADDR_W-1:0] ld_b_q, ld_b_d;
    logic              load_a, load_b;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ld_a_d  = ld_a_q;
        ld_b_d  = ld_b_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (op_a) begin
                    state_d = S_A_REQ;
                    load_a  = 1'b1;
                end else if (op_b) begin
                    state_d = S_B_REQ;
                    load_b  = 1'b1;
                end
            end
            S_A_REQ: if (dc_req_ready) state_d = S_A_WAIT;
            S_A_WAIT: begin
                if (dc_resp_valid) begin
                    if (!we_q) ld_a_d = dc_resp_rdata;
                    if (op_b) begin
                        state_d = S_B_REQ;
                        load_b  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_B_REQ: if (dc_req_ready) state_d = S_B_WAIT;
            S_B_WAIT: begin
                if (dc_resp_valid) begin
                    if (!we_q) ld_b_d = dc_resp_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Request fields only change on entry to a REQ state.
        if (load_a) begin
            we_d    = we_a;
            addr_d  = {MEM_alu_result_a[ADDR_W-1:2], 2'b00};
            wdata_d = wd_a;
            wstrb_d = strb_a;
        end else if (load_b) begin
            we_d    = we_b;
            addr_d  = {MEM_alu_result_b[ADDR_W-1:2], 2'b00};
            wdata_d = wd_b;
            wstrb_d = strb_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            ld_a_q  <= '0;
            ld_b_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ld_a_q  <= ld_a_d;
            ld_b_q  <= ld_b_d;
        end
    end

    assign stall_dcache  = (state_q != S_IDLE && state_q != S_DONE)
                         || (state_q == S_IDLE && (op_a || op_b));
    assign dc_req_valid  = (state_q == S_A_REQ) || (state_q == S_B_REQ);
    assign dc_req_we     = we_q;
    assign dc_req_addr   = addr_q;
    assign dc_req_wdata  = wdata_q;
    assign dc_req_wstrb  = wstrb_q;
    assign MEM_ld_data_a = ld_a_q;
    assign MEM_ld_data_b = ld_b_q;

endmodule
